status_collector: RTL
=====================

Name: status_collector

Overview:
- Sits directly downstream of the core's status port and consumes the o_status / o_status_valid stream, one entry per retired instruction.
- Buffers statuses in a small FIFO, drained by a ready/valid reader (bench monitor or trace dumper), and keeps per-type instruction counters.
- Detects the terminal status (overflow or end), then freezes capture and reports completion once the FIFO drains.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- CNT_W, 11, width of each per-type counter; saturating.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only when STATUS_COLLECTOR_WDOG_EN is defined.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_status  in  2  status code from core: 0 R_TYPE, 1 I_TYPE, 2 MIPS_OVERFLOW, 3 MIPS_END
- i_status_valid  in  1  status qualifier, single-cycle pulses
- o_rd_status  out  2  FIFO head status
- o_rd_valid  out  1  FIFO non-empty
- i_rd_ready  in  1  reader accepts head
- o_cnt_r  out  CNT_W  captured R_TYPE count
- o_cnt_i  out  CNT_W  captured I_TYPE count
- o_term  out  1  terminal status captured (sticky)
- o_term_code  out  2  captured terminal code (2 or 3)
- o_done  out  1  o_term && FIFO empty
- o_drop  out  1  sticky: a status arrived while the FIFO was full
- o_timeout  out  1  watchdog fired (0 when feature is compiled out)

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; FIFO empty; counters 0.
  - FSM enters CAPTURE.
  - Reset mid-stream discards all contents.
- FSM:
  - CAPTURE: accepts statuses.
  - CAPTURE → DRAIN when the accepted status is 2 or 3.
  - DRAIN: ignores i_status_valid; serves the reader only.
  - DRAIN → DONE when the FIFO is empty.
  - DONE: terminal; only reset leaves it.
- Write rules:
  - In CAPTURE, a valid status with the FIFO not full is written at the rising edge.
  - Matching counter increments the same edge, saturating at 2^CNT_W−1.
  - A terminal status is written into the FIFO too; o_term and o_term_code are set the same edge.
- Read rules:
  - Head pops when o_rd_valid && i_rd_ready.
  - o_rd_status and o_rd_valid are registered FIFO-head views. A write into an empty FIFO gives o_rd_valid=1 the next cycle (1-cycle latency).
- Simultaneous read and write:
  - When full: pop and push both succeed; no drop.
  - When empty: the write lands; o_rd_valid rises next cycle.
- Full without a read: status discarded, o_drop set (sticky), counters unchanged. A dropped terminal status still sets o_term and o_term_code and moves the FSM to DRAIN.
- Pointers: log2(DEPTH)+1 bits, wrap naturally. Full when MSBs differ and low bits are equal.
- o_done is a registered copy of (state==DONE).

Optional Feature:
- Macro: STATUS_COLLECTOR_WDOG_EN.
- Defined:
  - Counter runs in CAPTURE, cleared on each i_status_valid.
  - On reaching TIMEOUT_CYCLES: o_timeout=1 (sticky) and FSM goes to DRAIN as if terminal. o_term stays 0.
- Undefined: no counter logic; o_timeout tied 0.

Decomposition:
- Shared package status_pkg holds:
  - status code localparams: ST_R_TYPE=0, ST_I_TYPE=1, ST_OVERFLOW=2, ST_END=3
  - FSM state encoding: CAPTURE, DRAIN, DONE
- One sub-module: status_fifo, a generic DEPTH×2-bit synchronous FIFO with full/empty. The FSM and counters live in the top.

Test Plan:
- Reset check: with no input, all outputs read 0. Assert i_rst_n low mid-stream after 5 writes → FIFO empty and counters 0 immediately (asynchronous).
- Normal run: i_rd_ready=1; send 0,1,0,1,1,3 → reader sees the same order; o_cnt_r=2, o_cnt_i=3; o_term=1, o_term_code=3; o_done=1 one cycle after the last pop.
- Backpressure: i_rd_ready=0; send 20 R_TYPE statuses, DEPTH=16 → o_drop=1, o_cnt_r=16. Then raise ready → exactly 16 pops of 0.
- Post-terminal ignore: send 1 then 2, then 5 more 0s → o_term_code=2, o_cnt_r=0, FIFO yields 1,2 only.
- Full with concurrent read/write: fill 16 entries, then push while popping each cycle for 10 cycles → o_drop stays 0, order preserved.
- Watchdog (macro defined): TIMEOUT_CYCLES=50; send 3 statuses, then idle 50 cycles → o_timeout=1, o_term=0, o_done=1 after drain.

Source files
------------

// File: rtl/status_pkg.sv
`default_nettype none
// ============================================================================
// Module      : status_pkg
// Description : Status codes and FSM encoding shared by the status collector.
// Revision    : 1.0 - initial release
// ============================================================================
package status_pkg;

    localparam logic [1:0] ST_R_TYPE   = 2'd0;
    localparam logic [1:0] ST_I_TYPE   = 2'd1;
    localparam logic [1:0] ST_OVERFLOW = 2'd2;
    localparam logic [1:0] ST_END      = 2'd3;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Overflow and end are the only codes with the upper bit set.
    function automatic logic is_terminal(input logic [1:0] code);
        return code[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/status_fifo.sv
`default_nettype none
// ============================================================================
// Module      : status_fifo
// Description : Generic DEPTH x WIDTH synchronous FIFO with full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module status_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_rd_en && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = i_wr_en && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty   = w_empty;
    assign o_full    = w_full;

endmodule
`default_nettype wire

// File: rtl/status_collector.sv
`default_nettype none
// ============================================================================
// Module      : status_collector
// Description : Buffers core status entries, counts R/I types, detects the
//               terminal status and reports completion once drained.
//               Optional idle watchdog: define STATUS_COLLECTOR_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module status_collector
    import status_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int CNT_W          = 11,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_status,
    input  logic             i_status_valid,
    output logic [1:0]       o_rd_status,
    output logic             o_rd_valid,
    input  logic             i_rd_ready,
    output logic [CNT_W-1:0] o_cnt_r,
    output logic [CNT_W-1:0] o_cnt_i,
    output logic             o_term,
    output logic [1:0]       o_term_code,
    output logic             o_done,
    output logic             o_drop,
    output logic             o_timeout
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_empty;
    logic             w_full;
    logic             w_accept;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_is_term;
    logic             w_wdog_hit;
    logic [CNT_W-1:0] r_cnt_r;
    logic [CNT_W-1:0] r_cnt_i;
    logic             r_term;
    logic [1:0]       r_term_code;
    logic             r_done;
    logic             r_drop;

    assign w_accept  = (r_state == CAPTURE) && i_status_valid;
    assign w_pop     = o_rd_valid && i_rd_ready;
    assign w_push    = w_accept && (!w_full || w_pop);
    assign w_drop    = w_accept && w_full && !w_pop;
    // A terminal code ends capture even when the FIFO had no room for it.
    assign w_is_term = w_accept && is_terminal(i_status);

    status_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (w_push),
        .i_wr_data (i_status),
        .i_rd_en   (w_pop),
        .o_rd_data (o_rd_status),
        .o_empty   (w_empty),
        .o_full    (w_full)
    );

    assign o_rd_valid = !w_empty;

`ifdef STATUS_COLLECTOR_WDOG_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDOG_W-1:0] r_wdog_cnt;
    logic              r_timeout;

    assign w_wdog_hit = (r_state == CAPTURE) && !i_status_valid &&
                        (r_wdog_cnt == WDOG_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wdog_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (r_state != CAPTURE || i_status_valid) begin
                r_wdog_cnt <= '0;
            end else if (!w_wdog_hit) begin
                r_wdog_cnt <= r_wdog_cnt + 1'b1;
            end
            if (w_wdog_hit) r_timeout <= 1'b1;
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_wdog_hit = 1'b0;
    assign o_timeout  = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CAPTURE: if (w_is_term || w_wdog_hit) w_next_state = DRAIN;
            DRAIN:   if (w_empty) w_next_state = DONE;
            DONE:    w_next_state = DONE;
            default: w_next_state = CAPTURE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= CAPTURE;
            r_cnt_r     <= '0;
            r_cnt_i     <= '0;
            r_term      <= 1'b0;
            r_term_code <= 2'd0;
            r_done      <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // Registered from the next state so o_done lines up with DONE.
            r_done  <= (w_next_state == DONE);
            if (w_drop) r_drop <= 1'b1;
            if (w_push && i_status == ST_R_TYPE && r_cnt_r != C_CNT_MAX) begin
                r_cnt_r <= r_cnt_r + 1'b1;
            end
            if (w_push && i_status == ST_I_TYPE && r_cnt_i != C_CNT_MAX) begin
                r_cnt_i <= r_cnt_i + 1'b1;
            end
            if (w_is_term) begin
                r_term      <= 1'b1;
                r_term_code <= i_status;
            end
        end
    end

    assign o_cnt_r     = r_cnt_r;
    assign o_cnt_i     = r_cnt_i;
    assign o_term      = r_term;
    assign o_term_code = r_term_code;
    assign o_done      = r_done;
    assign o_drop      = r_drop;

endmodule
`default_nettype wire
